uart_byte_receiver: RTL

Serial-to-parallel UART receiver that sits directly upstream of the FIR control/datapath pair. It converts the raw `UART_RXD` line into validated 8-bit bytes. Each good byte is announced with a one-cycle `RxD_data_ready` pulse, which the FIR control unit uses to load the LSB and MSB halves of each FIR input sample. Frame format is 8N1, LSB first, 16× oversampled, with majority-vote bit sampling, false-start rejection and framing-error reporting.

---
 rtl/uart_byte_receiver_pkg.sv | 23 ++
 rtl/uart_byte_receiver_tick.sv | 36 +++
 rtl/uart_byte_receiver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_byte_receiver_pkg.sv
// Shared definitions for the UART byte receiver: FSM states, the baud divider
// computation and the oversampling sample points.
package uart_byte_receiver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam logic [3:0] T_SAMPLE_A = 4'd7;
   localparam logic [3:0] T_SAMPLE_B = 4'd8;
   localparam logic [3:0] T_DECIDE   = 4'd9;
   localparam logic [3:0] T_BIT_END  = 4'd15;

   // Rounded clock cycles per oversampling tick.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_byte_receiver_tick.sv
// Oversampling tick generator: clock divider plus a 4-bit position counter
// within the current bit, both held at zero while clear is asserted.
module baud_tick_gen #(
   parameter int DIV = 27
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       clear,
   output logic       tick,
   output logic [3:0] t
);

   localparam int CW = $clog2(DIV + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = (div_cnt == DIV_LAST);

   // t wraps from 15 back to 0, marking the start of the next bit.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         t       <= '0;
      end else if (clear) begin
         div_cnt <= '0;
         t       <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         t       <= t + 4'd1;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// false-start rejection and framing-error reporting.
module uart_byte_receiver
   import uart_byte_receiver_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       CLOCK_50,
   input  logic       KEY,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_idle,
   output logic       framing_error
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

   logic       rst_n;
   logic [1:0] rxd_meta;
   logic       rxd_sync;
   logic       tick;
   logic [3:0] t;
   logic       samp_a;
   logic       samp_b;
   logic       maj;
   logic       decide;
   logic       bit_end;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   rx_state_t  state;

   assign rst_n = KEY;

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 2'b11;
      end else begin
         rxd_meta <= {rxd_meta[0], RxD};
      end
   end

   assign rxd_sync = rxd_meta[1];

   // Counters sit at zero in IDLE so a new frame starts its timing at the edge.
   baud_tick_gen #(
      .DIV(DIV)
   ) u_tick (
      .clock(CLOCK_50),
      .rst_n(rst_n),
      .clear(state == ST_IDLE),
      .tick (tick),
      .t    (t)
   );

   assign maj      = (samp_a & samp_b) | (samp_a & rxd_sync) | (samp_b & rxd_sync);
   assign decide   = tick && (t == T_DECIDE);
   assign bit_end  = tick && (t == T_BIT_END);
   assign RxD_idle = (state == ST_IDLE);

   // Frame FSM; the third sample is the live synchronized line at the decision tick.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         bit_idx        <= '0;
         shreg          <= '0;
         samp_a         <= 1'b1;
         samp_b         <= 1'b1;
         RxD_data       <= '0;
         RxD_data_ready <= 1'b0;
         framing_error  <= 1'b0;
      end else begin
         RxD_data_ready <= 1'b0;
         framing_error  <= 1'b0;
         if (tick && (t == T_SAMPLE_A)) samp_a <= rxd_sync;
         if (tick && (t == T_SAMPLE_B)) samp_b <= rxd_sync;

         case (state)
            ST_IDLE: begin
               if (!rxd_sync) state <= ST_START;
            end
            ST_START: begin
               if (decide && maj) begin
                  state <= ST_IDLE;
               end else if (bit_end) begin
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (decide) shreg[bit_idx] <= maj;
               if (bit_end) begin
                  if (bit_idx == 3'd7) state <= ST_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end
            end
            // Leaving at mid-stop-bit keeps half a bit of slack for the next start edge.
            ST_STOP: begin
               if (decide) begin
                  if (maj) begin
                     RxD_data       <= shreg;
                     RxD_data_ready <= 1'b1;
                     state          <= ST_IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rxd_sync) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
